sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_accumulator_if.sv | 23 ++
 rtl/sum_accumulator.sv | 63 ++++++
 tb/tb_sum_accumulator.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sum_accumulator_if.sv
// sum_accumulator_if: input/output handshake bundle for the sum accumulator
interface sum_accumulator_if #(
    parameter int ACC_W = 10
);
    logic             in_valid;
    logic [4:0]       in_data;
    logic             in_ready;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             ovf;

    modport master (
        output in_valid, in_data, clear, out_ready,
        input  in_ready, out_valid, out_data, ovf
    );

    modport slave (
        input  in_valid, in_data, clear, out_ready,
        output in_ready, out_valid, out_data, ovf
    );
endinterface

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums NUM_SAMPLES 5-bit adder results per output word; define SUM_ACC_SAT_EN to clamp on overflow instead of wrapping
module sum_accumulator #(
    parameter int NUM_SAMPLES = 8,
    parameter int ACC_W       = 10
) (
    input logic              clk,
    input logic              rst,
    sum_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [7:0] LAST = 8'(NUM_SAMPLES - 1);

    state_t           state, nxt;
    logic [ACC_W-1:0] acc, ext, nxt_acc;
    logic [ACC_W:0]   sum;
    logic [7:0]       count;
    logic             ovf, in_xfer, out_xfer;

    assign bus.in_ready  = !rst && state != DONE;
    assign bus.out_valid = state == DONE;
    assign bus.out_data  = acc;
    assign bus.ovf       = ovf;
    assign in_xfer       = bus.in_valid && bus.in_ready;
    assign out_xfer      = bus.out_valid && bus.out_ready;
    assign ext           = {{(ACC_W-5){1'b0}}, bus.in_data};
    assign sum           = {1'b0, acc} + {1'b0, ext};
`ifdef SUM_ACC_SAT_EN
    assign nxt_acc       = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    assign nxt_acc       = sum[ACC_W-1:0];
`endif

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= nxt;

    // next state: clear wins, then load, last sample, output handoff
    always_comb begin
        nxt = state;
        if (bus.clear)                                   nxt = IDLE;
        else if (state == IDLE && in_xfer)               nxt = ACCUM;
        else if (state == ACCUM && in_xfer && count == LAST) nxt = DONE;
        else if (state == DONE && out_xfer)              nxt = IDLE;
    end

    // accumulator, sample count and sticky overflow
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (bus.clear || (state == DONE && out_xfer)) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (in_xfer) begin
            acc   <= state == IDLE ? ext : nxt_acc;
            count <= state == IDLE ? 8'd1 : count + 8'd1;
            ovf   <= ovf | (state == ACCUM && sum[ACC_W]);
        end
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: scoreboard bench for default and 8-bit/9-sample accumulator builds
module tb_sum_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic [16:0] e0, e1;
    logic [4:0] smp[8];
    int rsum;

    sum_accumulator_if #(.ACC_W(10)) b0();
    sum_accumulator_if #(.ACC_W(8))  b1();

    sum_accumulator #(.NUM_SAMPLES(8), .ACC_W(10)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    sum_accumulator #(.NUM_SAMPLES(9), .ACC_W(8))  dut1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic send0(input logic [4:0] d);
        b0.in_valid = 1'b1;
        b0.in_data  = d;
        @(posedge clk); #1;
        b0.in_valid = 1'b0;
    endtask

    task automatic send1(input logic [4:0] d);
        b1.in_valid = 1'b1;
        b1.in_data  = d;
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
    endtask

    // monitor: pop the expected word whenever an output transfer is about to happen
    always @(negedge clk) begin
        if (b0.out_valid && b0.out_ready) begin
            if (q0.size() == 0) chk("dut0 unexpected output", 32'(b0.out_data), 32'hffff_ffff);
            else begin
                e0 = q0.pop_front();
                chk("dut0 out_data", 32'(b0.out_data), 32'(e0[15:0]));
                chk("dut0 ovf", 32'(b0.ovf), 32'(e0[16]));
            end
        end
        if (b1.out_valid && b1.out_ready) begin
            if (q1.size() == 0) chk("dut1 unexpected output", 32'(b1.out_data), 32'hffff_ffff);
            else begin
                e1 = q1.pop_front();
                chk("dut1 out_data", 32'(b1.out_data), 32'(e1[15:0]));
                chk("dut1 ovf", 32'(b1.ovf), 32'(e1[16]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        b0.in_valid = 0; b0.in_data = 0; b0.clear = 0; b0.out_ready = 1;
        b1.in_valid = 0; b1.in_data = 0; b1.clear = 0; b1.out_ready = 1;
        #3;
        chk("reset in_ready", 32'(b0.in_ready), 0);
        chk("reset out_valid", 32'(b0.out_valid), 0);
        chk("reset out_data", 32'(b0.out_data), 0);
        chk("reset ovf", 32'(b0.ovf), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("release in_ready", 32'(b0.in_ready), 1);
        @(posedge clk); #1;

        // back-to-back 31s
        q0.push_back({1'b0, 16'd248});
        for (int i = 0; i < 7; i++) send0(5'd31);
        chk("b2b out_valid before 8th", 32'(b0.out_valid), 0);
        send0(5'd31);
        chk("b2b out_valid after 8th", 32'(b0.out_valid), 1);
        @(posedge clk); #1;
        chk("b2b in_ready after output", 32'(b0.in_ready), 1);

        // output stall with a competing input held high
        q0.push_back({1'b0, 16'd68});
        b0.out_ready = 1'b0;
        for (int i = 5; i <= 12; i++) send0(5'(i));
        b0.in_valid = 1'b1;
        b0.in_data  = 5'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall out_valid", 32'(b0.out_valid), 1);
            chk("stall out_data", 32'(b0.out_data), 68);
            chk("stall in_ready", 32'(b0.in_ready), 0);
        end
        b0.out_ready = 1'b1;
        @(posedge clk); #1;
        b0.in_valid = 1'b0;
        chk("stall released out_valid", 32'(b0.out_valid), 0);
        chk("stall released in_ready", 32'(b0.in_ready), 1);

        // clear mid-sum discards the same-cycle sample
        q0.push_back({1'b0, 16'd8});
        for (int i = 0; i < 3; i++) send0(5'd10);
        b0.clear = 1'b1;
        b0.in_valid = 1'b1;
        b0.in_data = 5'd10;
        @(posedge clk); #1;
        b0.clear = 1'b0;
        b0.in_valid = 1'b0;
        chk("clear out_valid", 32'(b0.out_valid), 0);
        for (int i = 0; i < 8; i++) send0(5'd1);
        @(posedge clk); #1;

        // asynchronous reset mid-sum
        for (int i = 0; i < 5; i++) send0(5'd3);
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(b0.out_valid), 0);
        chk("async rst in_ready", 32'(b0.in_ready), 0);
        chk("async rst out_data", 32'(b0.out_data), 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        q0.push_back({1'b0, 16'd16});
        for (int i = 0; i < 8; i++) send0(5'd2);
        @(posedge clk); #1;

        // in_valid toggling with random samples
        for (int r = 0; r < 2; r++) begin
            rsum = 0;
            for (int i = 0; i < 8; i++) begin
                smp[i] = 5'($urandom_range(0, 31));
                rsum += int'(smp[i]);
            end
            q0.push_back({1'b0, 16'(rsum)});
            for (int i = 0; i < 8; i++) begin
                send0(smp[i]);
                b0.in_data = 5'($urandom_range(0, 31));
                @(posedge clk); #1;
            end
        end

        // narrow accumulator overflow
        q1.push_back({1'b1,
`ifdef SUM_ACC_SAT_EN
            16'd255
`else
            16'd23
`endif
        });
        for (int i = 0; i < 8; i++) send1(5'd31);
        chk("dut1 partial acc", 32'(b1.out_data), 248);
        chk("dut1 partial ovf", 32'(b1.ovf), 0);
        send1(5'd31);
        chk("dut1 ovf set", 32'(b1.ovf), 1);
        @(posedge clk); #1;
        chk("dut1 ovf cleared", 32'(b1.ovf), 0);

        repeat (3) @(posedge clk);
        chk("dut0 outputs outstanding", q0.size(), 0);
        chk("dut1 outputs outstanding", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
